// File: rtl/fifo_rd_arb_pkg.sv
// Shared definitions for the packet-aware FWFT read arbiter:
// FSM state encoding and the ceil-log2 helper used for index and counter widths.
package fifo_rd_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_rd_arbiter_if.sv
// Queue-side and egress-side signals of the FWFT read arbiter.
// master: the arbiter (pops queues, drives the egress stage).
// slave:  the environment (queues plus downstream sink).
interface fifo_rd_arbiter_if #(
    parameter int NUM_QUEUES = 4,
    parameter int DATA_WIDTH = 64,
    parameter int SRC_BITS   = fifo_rd_arb_pkg::clog2(NUM_QUEUES)
);

    logic [NUM_QUEUES*DATA_WIDTH-1:0] Q_DATA;
    logic [NUM_QUEUES-1:0]            Q_LAST;
    logic [NUM_QUEUES-1:0]            Q_EMPTY;
    logic [NUM_QUEUES-1:0]            Q_RD_EN;
    logic [DATA_WIDTH-1:0]            M_DATA;
    logic                             M_LAST;
    logic [SRC_BITS-1:0]              M_SRC;
    logic                             M_VALID;
    logic                             M_READY;
    logic                             TRUNC_ERR;

    modport master (
        input  Q_DATA, Q_LAST, Q_EMPTY, M_READY,
        output Q_RD_EN, M_DATA, M_LAST, M_SRC, M_VALID, TRUNC_ERR
    );

    modport slave (
        output Q_DATA, Q_LAST, Q_EMPTY, M_READY,
        input  Q_RD_EN, M_DATA, M_LAST, M_SRC, M_VALID, TRUNC_ERR
    );

endinterface

// File: rtl/fifo_rd_arb_rr_pick.sv
// Combinational rotating-priority encoder: returns the first requester found
// searching upward from rr and wrapping modulo NUM_QUEUES.
module fifo_rd_arb_rr_pick
    import fifo_rd_arb_pkg::*;
#(
    parameter int NUM_QUEUES = 4,
    parameter int SRC_BITS   = clog2(NUM_QUEUES)
) (
    input  logic [NUM_QUEUES-1:0] req,
    input  logic [SRC_BITS-1:0]   rr,
    output logic                  any,
    output logic [SRC_BITS-1:0]   winner
);

    // Scan from farthest to nearest so the nearest requester after rr wins.
    always_comb begin
        int idx;
        any    = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
            idx = int'(rr) + i;
            if (idx >= NUM_QUEUES) begin
                idx = idx - NUM_QUEUES;
            end
            if (req[idx]) begin
                any    = 1'b1;
                winner = SRC_BITS'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Packet-aware read-side arbiter for NUM_QUEUES FWFT FIFOs. Grants one
// non-empty queue, drains one packet (or MAX_PKT_BEATS beats) into a
// registered valid/ready stage, then re-arbitrates.
// Build option: FIFO_RD_ARB_STRICT_PRIO_EN selects lowest-index-wins
// arbitration instead of round-robin.
module fifo_rd_arbiter
    import fifo_rd_arb_pkg::*;
#(
    parameter int NUM_QUEUES    = 4,
    parameter int DATA_WIDTH    = 64,
    parameter int MAX_PKT_BEATS = 256,
    parameter int SRC_BITS      = clog2(NUM_QUEUES)
) (
    input logic               CLK,
    input logic               RST,
    fifo_rd_arbiter_if.master bus
);

    localparam int CNT_W = clog2(MAX_PKT_BEATS + 1);

    state_e                state_q, state_d;
    logic [SRC_BITS-1:0]   g_q, g_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_last_q, m_last_d;
    logic [SRC_BITS-1:0]   m_src_q, m_src_d;
    logic                  m_valid_q, m_valid_d;
`ifndef FIFO_RD_ARB_STRICT_PRIO_EN
    logic [SRC_BITS-1:0]   rr_q, rr_d;
`endif

    logic [SRC_BITS-1:0]   rr_sel;
    logic                  any;
    logic [SRC_BITS-1:0]   winner;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  head_last;
    logic                  head_empty;
    logic                  limit_hit;
    logic                  pop;
    logic                  pkt_end;
    logic [NUM_QUEUES-1:0] q_rd_en;

`ifdef FIFO_RD_ARB_STRICT_PRIO_EN
    assign rr_sel = '0;
`else
    assign rr_sel = rr_q;
`endif

    fifo_rd_arb_rr_pick #(
        .NUM_QUEUES(NUM_QUEUES),
        .SRC_BITS  (SRC_BITS)
    ) u_pick (
        .req   (~bus.Q_EMPTY),
        .rr    (rr_sel),
        .any   (any),
        .winner(winner)
    );

    // Head of the granted queue, pop qualification and packet-end decode.
    // NOTE: every signal written in a combinational block gets a default first so no latch is inferred.
    always_comb begin
        head_data  = bus.Q_DATA[g_q*DATA_WIDTH +: DATA_WIDTH];
        head_last  = bus.Q_LAST[g_q];
        head_empty = bus.Q_EMPTY[g_q];
        limit_hit  = (int'(cnt_q) + 1) == MAX_PKT_BEATS;
        pop        = (state_q == BUSY) & ~RST & ~head_empty & (~m_valid_q | bus.M_READY);
        pkt_end    = pop & (head_last | limit_hit);
        q_rd_en        = '0;
        q_rd_en[g_q]   = pop;
    end

    // Next-state logic: arbitration in IDLE, beat transfer in BUSY, output drain.
    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        cnt_d     = cnt_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        m_src_d   = m_src_q;
        m_valid_d = m_valid_q;
`ifndef FIFO_RD_ARB_STRICT_PRIO_EN
        rr_d      = rr_q;
`endif
        case (state_q)
            IDLE: begin
                if (any) begin
                    g_d     = winner;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (pop) begin
                    m_data_d  = head_data;
                    m_last_d  = head_last | limit_hit;
                    m_src_d   = g_q;
                    m_valid_d = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                end
                if (pkt_end) begin
                    state_d = IDLE;
`ifndef FIFO_RD_ARB_STRICT_PRIO_EN
                    rr_d    = (int'(g_q) == NUM_QUEUES - 1) ? '0 : g_q + 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        if (m_valid_q & bus.M_READY & ~pop) begin
            m_valid_d = 1'b0;
        end
    end

    // State and output-stage registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            g_q       <= '0;
            cnt_q     <= '0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            m_src_q   <= '0;
            m_valid_q <= 1'b0;
`ifndef FIFO_RD_ARB_STRICT_PRIO_EN
            rr_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            cnt_q     <= cnt_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            m_src_q   <= m_src_d;
            m_valid_q <= m_valid_d;
`ifndef FIFO_RD_ARB_STRICT_PRIO_EN
            rr_q      <= rr_d;
`endif
        end
    end

    assign bus.Q_RD_EN   = q_rd_en;
    assign bus.TRUNC_ERR = pop & limit_hit & ~head_last;
    assign bus.M_DATA    = m_data_q;
    assign bus.M_LAST    = m_last_q;
    assign bus.M_SRC     = m_src_q;
    assign bus.M_VALID   = m_valid_q;

endmodule
